// File: rtl/mdata_hs_pkg.sv
// Shared definitions for the multi-bit req/ack CDC handshake agents (send and receive side).
`timescale 1ns/1ps
package mdata_hs_pkg;

    // Four-phase handshake states as seen by the sending agent.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } hs_state_t;

    localparam int DW_DEFAULT   = 8;
    localparam int SYNC_DEFAULT = 2;

endpackage : mdata_hs_pkg

// File: rtl/cdc_bit_sync.sv
// Single-bit synchroniser: a plain chain of STAGES flops, cleared to 0 by reset.
`timescale 1ns/1ps
module cdc_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the asynchronous input one stage further down the chain each edge.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // Synchroniser flops with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : cdc_bit_sync

// File: rtl/mdata_hs_tx.sv
// Sending-side agent of the multi-bit req/ack CDC handshake: a small FIFO feeding
// one word at a time onto data_o, qualified by a 4-phase req_o/ack_i exchange.
`timescale 1ns/1ps
module mdata_hs_tx
    import mdata_hs_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = SYNC_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_vld,
    input  logic [DW-1:0]                din,
    output logic                         in_rdy,
    output logic                         req_o,
    output logic [DW-1:0]                data_o,
    input  logic                         ack_i,
    output logic                         done_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Full when the wrap bits differ and the index bits match.
    function automatic logic ptr_full(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
        return (wr[PW-1] != rd[PW-1]) && (wr[AW-1:0] == rd[AW-1:0]);
    endfunction

    logic [DW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  ptr_diff_s;
    logic [LW-1:0]  level_q, level_d;
    logic           in_rdy_q, in_rdy_d;
    logic           req_q, req_d;
    logic [DW-1:0]  data_q, data_d;
    logic           done_q, done_d;
    hs_state_t      state_q, state_d;

    logic           ack_s;
    logic           push_s;
    logic           pop_s;
    logic           empty_s;

    cdc_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (ack_i),
        .q_o   (ack_s)
    );

    assign push_s  = in_vld & in_rdy_q;
    assign empty_s = (wr_ptr_q == rd_ptr_q);

    // Handshake FSM: launch from the FIFO head only when the far end has released ack.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_s && !ack_s) begin
                    pop_s   = 1'b1;
                    data_d  = mem_q[rd_ptr_q[AW-1:0]];
                    req_d   = 1'b1;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = DROP;
                end else begin
                    state_d = REQ;
                end
            end
            DROP: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Pointer, occupancy and ready bookkeeping; ready looks at the post-update pointers.
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        ptr_diff_s = wr_ptr_d - rd_ptr_d;
        level_d    = LW'(ptr_diff_s);
        in_rdy_d   = !ptr_full(wr_ptr_d, rd_ptr_d);
    end

    // Control and output registers with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {LW{1'b0}};
            in_rdy_q <= 1'b0;
            req_q    <= 1'b0;
            data_q   <= {DW{1'b0}};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            in_rdy_q <= in_rdy_d;
            req_q    <= req_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    // FIFO storage; contents are meaningless after reset because the pointers are cleared.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign in_rdy  = in_rdy_q;
    assign req_o   = req_q;
    assign data_o  = data_q;
    assign done_o  = done_q;
    assign level_o = level_q;

endmodule : mdata_hs_tx

// File: tb/tb_mdata_hs_tx.sv
// Directed + randomized bench for mdata_hs_tx with a slow-clock responder and a FIFO-order model.
`timescale 1ns/1ps
module tb_mdata_hs_tx;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic          clk_i = 1'b0;
    logic          rclk  = 1'b0;
    logic          rst_i = 1'b1;
    logic          in_vld = 1'b0;
    logic [DW-1:0] din = 8'h00;
    logic          in_rdy;
    logic          req_o;
    logic [DW-1:0] data_o;
    logic          ack_i;
    logic          done_o;
    logic [2:0]    level_o;

    // Responder side state and ack override used for stall/stuck scenarios.
    logic          rs1 = 1'b0, rs2 = 1'b0, ack_r = 1'b0;
    logic          force_en = 1'b0;
    logic          force_val = 1'b0;

    int            checks = 0;
    int            failures = 0;
    int            done_cnt = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] all_q [$];
    logic [DW-1:0] capt_q [$];

    assign ack_i = force_en ? force_val : ack_r;

    mdata_hs_tx #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .in_vld  (in_vld),
        .din     (din),
        .in_rdy  (in_rdy),
        .req_o   (req_o),
        .data_o  (data_o),
        .ack_i   (ack_i),
        .done_o  (done_o),
        .level_o (level_o)
    );

    initial forever #0.5 clk_i = ~clk_i;
    initial begin
        #0.3;
        forever #1 rclk = ~rclk;
    end

    // Far-end responder: 2-flop req sync, ack follows the synchronised req one cycle later.
    always @(posedge rclk or posedge rst_i) begin
        if (rst_i) begin
            rs1   <= 1'b0;
            rs2   <= 1'b0;
            ack_r <= 1'b0;
        end else begin
            rs1   <= req_o;
            rs2   <= rs1;
            ack_r <= rs2;
            if (rs2 && !ack_r) capt_q.push_back(data_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake monitor: launch order/data, data stability while busy, one done per launch.
    initial begin
        logic          active;
        logic          req_prev;
        logic [DW-1:0] hold;
        active = 1'b0;
        req_prev = 1'b0;
        hold = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                active = 1'b0;
                req_prev = 1'b0;
            end else begin
                if (req_o && !req_prev) begin
                    check("launch_after_done", {31'd0, active}, 32'd0);
                    if (exp_q.size() == 0) begin
                        check("launch_unexpected", 32'd1, 32'd0);
                    end else begin
                        check("launch_data", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
                    end
                    active = 1'b1;
                    hold = data_o;
                end else if (active) begin
                    check("data_stable", {24'd0, data_o}, {24'd0, hold});
                end
                if (done_o) begin
                    done_cnt++;
                    check("done_in_handshake", {31'd0, active}, 32'd1);
                    active = 1'b0;
                end
                req_prev = req_o;
            end
        end
    end

    // Offer one word and hold it until the DUT takes it (bounded).
    task automatic push(input logic [DW-1:0] w);
        bit got;
        got = 1'b0;
        in_vld = 1'b1;
        din = w;
        for (int k = 0; k < 400; k++) begin
            if (in_rdy) begin
                @(negedge clk_i);
                got = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        in_vld = 1'b0;
        if (got) begin
            exp_q.push_back(w);
            all_q.push_back(w);
        end else begin
            check("push_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 3000; k++) begin
            if (done_cnt >= target && !req_o) break;
            @(negedge clk_i);
        end
        repeat (4) @(negedge clk_i);
        check("done_count", done_cnt, target);
        check("model_drained", exp_q.size(), 32'd0);
    endtask

    task automatic compare_capture();
        check("capture_count", capt_q.size(), all_q.size());
        for (int i = 0; i < all_q.size() && i < capt_q.size(); i++) begin
            check("capture_word", {24'd0, capt_q[i]}, {24'd0, all_q[i]});
        end
        capt_q.delete();
        all_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        exp_q.delete();
        all_q.delete();
        capt_q.delete();
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        int base;
        int n_acc;
        // Reset values while held, then in_rdy opens one edge after release.
        repeat (3) @(negedge clk_i);
        check("rst_req", {31'd0, req_o}, 32'd0);
        check("rst_data", {24'd0, data_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_level", {29'd0, level_o}, 32'd0);
        check("rst_in_rdy", {31'd0, in_rdy}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
        check("post_rst_req", {31'd0, req_o}, 32'd0);
        check("post_rst_level", {29'd0, level_o}, 32'd0);

        // Single word: one cycle in the FIFO, then launched.
        base = done_cnt;
        push(8'h04);
        check("single_level_after_push", {29'd0, level_o}, 32'd1);
        check("single_req_not_yet", {31'd0, req_o}, 32'd0);
        @(negedge clk_i);
        check("single_req", {31'd0, req_o}, 32'd1);
        check("single_data", {24'd0, data_o}, 32'h04);
        check("single_level_after_pop", {29'd0, level_o}, 32'd0);
        wait_done(base + 1);
        check("single_level_end", {29'd0, level_o}, 32'd0);
        compare_capture();

        // Burst of three back-to-back words.
        base = done_cnt;
        push(8'h04);
        push(8'h05);
        push(8'h0A);
        wait_done(base + 3);
        compare_capture();

        // Random words with random idle gaps.
        base = done_cnt;
        for (int i = 0; i < 20; i++) begin
            push(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end
        wait_done(base + 20);
        compare_capture();

        // Stalled far end: one word in flight plus a full FIFO, further words held off.
        force_en = 1'b1;
        force_val = 1'b0;
        base = done_cnt;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (!in_rdy) break;
            push(8'hA0 + 8'(i));
            n_acc++;
        end
        check("full_accepted", n_acc, DEPTH + 1);
        check("full_level", {29'd0, level_o}, DEPTH);
        check("full_in_rdy", {31'd0, in_rdy}, 32'd0);
        in_vld = 1'b1;
        din = 8'hEE;
        repeat (10) @(negedge clk_i);
        check("full_hold_level", {29'd0, level_o}, DEPTH);
        check("full_hold_in_rdy", {31'd0, in_rdy}, 32'd0);
        force_en = 1'b0;
        push(8'hEE);
        wait_done(base + n_acc + 1);
        compare_capture();

        // Stuck ack from reset: no launch until the synchronised ack falls.
        force_en = 1'b1;
        force_val = 1'b1;
        do_reset();
        base = done_cnt;
        push(8'h55);
        repeat (8) @(negedge clk_i);
        check("stuck_req_low", {31'd0, req_o}, 32'd0);
        check("stuck_level", {29'd0, level_o}, 32'd1);
        force_val = 1'b0;
        repeat (SYNC) @(negedge clk_i);
        check("stuck_req_still_low", {31'd0, req_o}, 32'd0);
        @(negedge clk_i);
        check("stuck_req_rise", {31'd0, req_o}, 32'd1);
        check("stuck_data", {24'd0, data_o}, 32'h55);
        force_en = 1'b0;
        wait_done(base + 1);
        compare_capture();

        // Reset in the middle of a handshake with two words queued.
        force_en = 1'b1;
        force_val = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("mid_req", {31'd0, req_o}, 32'd1);
        check("mid_level", {29'd0, level_o}, 32'd2);
        base = done_cnt;
        #0.2;
        rst_i = 1'b1;
        #0.1;
        check("mid_rst_req", {31'd0, req_o}, 32'd0);
        check("mid_rst_level", {29'd0, level_o}, 32'd0);
        exp_q.delete();
        all_q.delete();
        capt_q.delete();
        repeat (3) @(negedge clk_i);
        force_en = 1'b0;
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check("mid_no_done", done_cnt, base);
        check("mid_req_idle", {31'd0, req_o}, 32'd0);
        check("mid_level_idle", {29'd0, level_o}, 32'd0);
        check("mid_in_rdy", {31'd0, in_rdy}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mdata_hs_tx
